// File: rtl/circle_span_gen.sv
// rtl/circle_span_gen.sv - midpoint circle rasteriser streaming outline points or fill spans
module circle_span_gen #(
    parameter int WIDTH        = 32,
    parameter bit FILL_DEFAULT = 1'b0
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic signed [WIDTH-1:0] i_s_x,
    input  logic signed [WIDTH-1:0] i_s_y,
    input  logic signed [WIDTH-1:0] i_radius,
    input  logic                    i_mode,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic signed [WIDTH-1:0] o_out0,
    output logic signed [WIDTH-1:0] o_out1,
    output logic signed [WIDTH-1:0] o_out2,
    output logic                    o_done,
    output logic                    o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_STEP,
        S_REJECT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [WIDTH-1:0] r_cx;
    logic signed [WIDTH-1:0] r_cy;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH+1:0] r_d;
    logic                    r_mode;
    logic [2:0]              r_k;

    logic signed [WIDTH-1:0] w_y_inc;
    logic signed [WIDTH-1:0] w_x_dec;
    logic signed [WIDTH-1:0] w_x_step;
    logic signed [WIDTH+1:0] w_y_ext;
    logic signed [WIDTH+1:0] w_x_ext;
    logic signed [WIDTH+1:0] w_d_step;
    logic signed [WIDTH+1:0] w_d_init;
    logic                    w_d_neg;
    logic                    w_continue;
    logic [2:0]              w_k_last;
    logic                    w_last;
    logic                    w_swap;
    logic signed [WIDTH-1:0] w_a;
    logic signed [WIDTH-1:0] w_b;

    // Step arithmetic: y advances first, then x and d use the advanced values.
    assign w_y_inc    = r_y + 1'b1;
    assign w_x_dec    = r_x - 1'b1;
    assign w_d_neg    = r_d[WIDTH+1];
    assign w_x_step   = w_d_neg ? r_x : w_x_dec;
    assign w_y_ext    = {{2{w_y_inc[WIDTH-1]}}, w_y_inc};
    assign w_x_ext    = {{2{w_x_dec[WIDTH-1]}}, w_x_dec};
    assign w_d_step   = w_d_neg ? (r_d + (w_y_ext <<< 1) + (WIDTH+2)'(1))
                                : (r_d + ((w_y_ext - w_x_ext) <<< 1) + (WIDTH+2)'(1));
    assign w_continue = (w_x_step >= w_y_inc);
    assign w_d_init   = (WIDTH+2)'(1) - {{2{i_radius[WIDTH-1]}}, i_radius};

    assign w_k_last = r_mode ? 3'd3 : 3'd7;
    assign w_last   = (r_k == w_k_last);

    // Second half of each step's outputs swaps the roles of x and y.
    assign w_swap = r_mode ? r_k[1] : r_k[2];
    assign w_a    = w_swap ? r_y : r_x;
    assign w_b    = w_swap ? r_x : r_y;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = i_radius[WIDTH-1] ? S_REJECT : S_EMIT;
                end
            end
            S_EMIT: begin
                if (i_ready && w_last) begin
                    w_state_next = S_STEP;
                end
            end
            S_STEP:   w_state_next = w_continue ? S_EMIT : S_DONE;
            S_REJECT: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_d    <= '0;
            r_mode <= FILL_DEFAULT;
            r_k    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cx   <= i_s_x;
                        r_cy   <= i_s_y;
                        r_x    <= i_radius;
                        r_y    <= '0;
                        r_d    <= w_d_init;
                        r_mode <= i_mode;
                        r_k    <= '0;
                    end
                end
                S_EMIT: begin
                    if (i_ready) begin
                        r_k <= w_last ? 3'd0 : r_k + 3'd1;
                    end
                end
                S_STEP: begin
                    r_y <= w_y_inc;
                    r_x <= w_x_step;
                    r_d <= w_d_step;
                    r_k <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_valid = (r_state == S_EMIT);
        o_busy  = (r_state == S_EMIT) || (r_state == S_STEP) || (r_state == S_REJECT);
        o_done  = (r_state == S_DONE);
        o_out0  = '0;
        o_out1  = '0;
        o_out2  = '0;
        if (r_state == S_EMIT) begin
            if (r_mode) begin
                o_out0 = r_cx - w_a;
                o_out2 = r_cx + w_a;
                o_out1 = r_k[0] ? (r_cy - w_b) : (r_cy + w_b);
            end else begin
                o_out0 = r_k[0] ? (r_cx - w_a) : (r_cx + w_a);
                o_out1 = r_k[1] ? (r_cy - w_b) : (r_cy + w_b);
                o_out2 = o_out0;
            end
        end
    end

endmodule

// File: doc/circle_span_gen.md
Name: circle_span_gen

Overview:
- Parametrised successor to the fixed-width circle generator in the generator library.
- Rasterises a circle of given centre and radius with the integer midpoint algorithm.
- Streams results over a valid/ready handshake with backpressure.
- Two modes: OUTLINE emits 8 points per algorithm step; FILL emits 4 horizontal spans per step.
- Sits between a host that issues draw commands and a downstream pixel/span writer.

Parameters:
- WIDTH, 32, signed bit width of coordinates, radius and outputs.
- FILL_DEFAULT, 0, mode used when `mode` is driven X/unused; informational only, `mode` is always sampled.

Ports:
- _clock  in  1  rising-edge clock.
- _reset_n  in  1  synchronous active-low reset.
- _start  in  1  command strobe, sampled only in IDLE.
- s_x  in  WIDTH  signed centre x.
- s_y  in  WIDTH  signed centre y.
- radius  in  WIDTH  signed radius.
- mode  in  1  0 = OUTLINE, 1 = FILL.
- _ready  in  1  downstream accepts the current output.
- _valid  out  1  _out0.._out2 hold a result.
- _out0  out  WIDTH  span start x (point x in OUTLINE).
- _out1  out  WIDTH  y.
- _out2  out  WIDTH  span end x (equal to _out0 in OUTLINE).
- _done  out  1  one-cycle completion pulse.
- _busy  out  1  high from command accept until _done.

Behaviour:

Reset:
- While `_reset_n` is low at a posedge: state goes to IDLE; `_valid`, `_done`, `_busy` and `_out0`..`_out2` all go to 0.
- This applies mid-operation; the command in progress is abandoned with no `_done`.

Command accept:
- In IDLE, `_start` = 1 at edge N latches s_x, s_y, radius and mode.
- Initialises x = radius, y = 0, d = 1 - radius. d is WIDTH+2 bits signed internally.
- `_busy` = 1 from N+1.
- If radius < 0: go to DONE; no outputs are emitted.
- Otherwise go to EMIT with index k = 0. The first `_valid` appears at N+1.
- `_start` is ignored while not in IDLE.

States:
- IDLE: waits for `_start`.
- EMIT: presents output k.
  - A handshake occurs when `_valid` & `_ready` at a posedge.
  - On a handshake, k increments. After the last index (7 in OUTLINE, 3 in FILL), go to STEP.
  - While `_ready` = 0, all outputs hold stable.
- STEP: one cycle with `_valid` = 0.
  - Update order: y ← y + 1; if d < 0 then d ← d + 2y + 1, else { x ← x − 1; d ← d + 2(y − x) + 1 }. New values are used throughout.
  - If x ≥ y, go to EMIT with k = 0; otherwise go to DONE.
- DONE: `_done` = 1 for exactly one cycle with `_busy` = 0, then go to IDLE. A `_start` in the DONE cycle is ignored.

OUTLINE order for k = 0..7 (cx, cy are the latched centre):
- (cx+x, cy+y), (cx−x, cy+y), (cx+x, cy−y), (cx−x, cy−y)
- (cx+y, cy+x), (cx−y, cy+x), (cx+y, cy−x), (cx−y, cy−x)

FILL order for k = 0..3, each given as (_out0, _out2, _out1):
- (cx−x, cx+x, cy+y)
- (cx−x, cx+x, cy−y)
- (cx−y, cx+y, cy+x)
- (cx−y, cx+y, cy−x)

Arithmetic and duplicates:
- Output arithmetic wraps modulo 2^WIDTH.
- Duplicate points and spans (y = 0, x = y) are emitted, not suppressed.

Throughput:
- With `_ready` held at 1, one output per cycle, plus one STEP bubble per algorithm step.

Test Plan:
1. s_x=23, s_y=17, radius=3, mode=0, `_ready`=1 → exactly 24 outputs (3 steps of 8).
   - First output (26,17,26), second (20,17,20).
   - Steps use (x,y) = (3,0), (3,1), (2,2).
   - `_done` is pulsed once, 1 cycle after the STEP following the 24th output; no `_valid` after it.
2. Same command with mode=1 → 12 spans.
   - First (20,26,17), third (23,23,20).
   - Last span of step 3 is (21,25,15).
3. radius=0, centre (5,5), mode=0 → 8 outputs, all (5,5,5), then `_done`.
   - radius=1 → 8 outputs from step (1,0), then `_done`.
4. radius=3 with `_ready` toggled 1,0,0,1 repeatedly → same 24-output sequence as case 1.
   - Outputs are stable during every stall; no drops or repeats.
5. radius=−4 → no `_valid`; `_busy` for 1 cycle, then `_done` 1 cycle.
   - `_start` pulses during busy are ignored.
6. Assert `_reset_n`=0 for one edge midway through case 1 → next cycle `_valid`, `_busy`, `_done` and `_out0`..`_out2` are 0 and state is IDLE.
   - A fresh `_start` then reproduces case 1 exactly.
